// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, state layout, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;
  localparam int AES_RK_W  = 1408;

  // Column-major state; byte k of the block lives at index 15-k so the
  // packed vector lines up bit-for-bit with the 128-bit bus.
  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // col = {row0, row1, row2, row3}
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Block-in / ciphertext-out handshake bundle for the iterative AES core.
interface aes_encrypt_iter_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] plaintext;
  logic [AES_RK_W-1:0]  round_keys;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] ciphertext;

  modport master (
    output in_valid, plaintext, round_keys, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, round_keys, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 is_final,
  output logic [AES_BLK_W-1:0] state_out
);
  aes_state_t st_in, sb, sr, mc;

  assign st_in = state_in;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (st_in[gi]),
      .out_byte (sb[gi])
    );
  end

  // Output byte (col c, row r) takes the input byte from column (c+r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int C = gi / 4;
    localparam int R = gi % 4;
    assign sr[15-gi] = sb[15-(4*((C+R)%4)+R)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mc[15-4*gi -: 4] = mix_column({sr[15-4*gi], sr[14-4*gi],
                                          sr[13-4*gi], sr[12-4*gi]});
  end

  assign state_out = (is_final ? sr : mc) ^ rk;
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock behind a valid/ready handshake.
// Define AES_KEY_LATCH_EN to capture round_keys on accept instead of using them live.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input logic               clk,
  input logic               rst,
  aes_encrypt_iter_if.slave bus
);
  localparam logic [3:0] NR_L = 4'(NR);

  aes_fsm_t             fsm_q, fsm_d;
  logic [AES_BLK_W-1:0] state_q, state_d;
  logic [3:0]           rnd_q, rnd_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [AES_RK_W-1:0]  key_src;
  logic [AES_BLK_W-1:0] rk_arr [16];
  logic [AES_BLK_W-1:0] round_out;
  logic                 accept;

  assign accept = bus.in_valid && in_ready_q;

`ifdef AES_KEY_LATCH_EN
  logic [AES_RK_W-1:0] keys_q, keys_d;

  always_comb begin
    keys_d = keys_q;
    if (accept) begin
      keys_d = bus.round_keys;
    end
  end

  assign key_src = keys_q;
`else
  assign key_src = bus.round_keys;
`endif

  // Pad to 16 entries so every 4-bit counter value selects something defined.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rk
    if (gi <= AES_NR) begin : g_live
      assign rk_arr[gi] = key_src[AES_BLK_W*gi +: AES_BLK_W];
    end else begin : g_pad
      assign rk_arr[gi] = '0;
    end
  end

  aes_round u_round (
    .state_in  (state_q),
    .rk        (rk_arr[rnd_q]),
    .is_final  (rnd_q == NR_L),
    .state_out (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          // Round key 0 always comes straight off the bus at accept time.
          state_d    = bus.plaintext ^ bus.round_keys[AES_BLK_W-1:0];
          rnd_d      = 4'd1;
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
        end
      end
      ROUND: begin
        if (rnd_q > NR_L) begin
          fsm_d      = IDLE;
          rnd_d      = 4'd0;
          in_ready_d = 1'b1;
        end else begin
          state_d = round_out;
          if (rnd_q == NR_L) begin
            fsm_d       = DONE;
            out_valid_d = 1'b1;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d       = IDLE;
          rnd_d       = 4'd0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d       = IDLE;
        rnd_d       = 4'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef AES_KEY_LATCH_EN
      keys_q      <= '0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef AES_KEY_LATCH_EN
      keys_q      <= keys_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ciphertext = state_q;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using FIPS-197 vectors; expands keys locally.
module tb_aes_encrypt_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_encrypt_iter_if bus ();

  aes_encrypt_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_tab [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Stand-in for the upstream key-expansion block: AES-128 key schedule.
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [1407:0] keys);
    int n = 0;
    @(negedge clk);
    bus.plaintext  = pt;
    bus.round_keys = keys;
    bus.in_valid   = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle, so out_valid seen after edge T+10 gives 11.
  task automatic wait_out(input string tag, input logic [127:0] exp_ct);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, 128'(n + 1), 128'd11);
    check_val({tag, "_ct"}, bus.ciphertext, exp_ct);
    $display("xfer %s ct=%h lat=%0d", tag, bus.ciphertext, n + 1);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_post_ov"}, 128'(bus.out_valid), 128'd0);
    check_val({tag, "_post_rdy"}, 128'(bus.in_ready), 128'd1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt,
                           input logic [1407:0] keys, input logic [127:0] exp_ct);
    send(pt, keys);
    wait_out(tag, exp_ct);
    consume(tag);
  endtask

  logic [127:0]  pts  [3];
  logic [127:0]  cts  [3];
  logic [1407:0] ks   [3];
  logic          saw_ov;
  int            nin, nout, last;

  initial begin
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.plaintext  = '0;
    bus.round_keys = '0;
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734;
    cts[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    ks[0]  = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pts[1] = 128'h00112233445566778899aabbccddeeff;
    cts[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ks[1]  = expand(128'h000102030405060708090a0b0c0d0e0f);
    pts[2] = 128'h0;
    cts[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    ks[2]  = expand(128'h0);

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check_val("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_val("rst_ct", bus.ciphertext, 128'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", 128'(bus.in_ready), 128'd1);

    run_block("fips_b", pts[0], ks[0], cts[0]);
    run_block("fips_c1", pts[1], ks[1], cts[1]);

    // Backpressure with a stray in_valid that must be dropped, not queued.
    send(pts[2], ks[2]);
    wait_out("bp", cts[2]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.plaintext = pts[0];
      check_val("bp_ct_stable", bus.ciphertext, cts[2]);
      check_val("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    consume("bp");
    saw_ov = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) saw_ov = 1'b1;
    end
    check_val("bp_no_queued", 128'(saw_ov), 128'd0);

    // Back-to-back: in_valid and out_ready held high.
    nin = 0; nout = 0; last = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 80 && nout < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check_val("b2b_ct", bus.ciphertext, cts[nout]);
        if (nout > 0) check_val("b2b_spacing", 128'(c - last), 128'd12);
        $display("xfer b2b%0d ct=%h cyc=%0d", nout, bus.ciphertext, c);
        last = c;
        nout++;
      end
      if (bus.in_ready && nin < 3) begin
        bus.plaintext  = pts[nin];
        bus.round_keys = ks[nin];
        bus.in_valid   = 1'b1;
        nin++;
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check_val("b2b_count", 128'(nout), 128'd3);

    // Reset in the middle of a block, then a fresh block.
    send(pts[0], ks[0]);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_ov", 128'(bus.out_valid), 128'd0);
    check_val("mid_rst_rdy", 128'(bus.in_ready), 128'd0);
    check_val("mid_rst_ct", bus.ciphertext, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_ov = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) saw_ov = 1'b1;
    end
    check_val("mid_rst_no_stale", 128'(saw_ov), 128'd0);
    run_block("after_rst", pts[1], ks[1], cts[1]);

`ifdef AES_KEY_LATCH_EN
    send(pts[0], ks[0]);
    @(negedge clk);
    bus.round_keys = {44{$urandom()}};
    wait_out("latched", cts[0]);
    consume("latched");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
